qs_srt_fetch: RTL and testbench

Instruction-fetch stage for the qs_srt sort microsequencer. Sits directly upstream of the ucode decoder: generates PCs, reads the synchronous instruction ROM (1-cycle read latency) and presents a valid/accept stream of inst_t words to decode.
Handles program start, redirect on taken jump/call/ret from execute, and halt on DONE. A 2-entry output queue absorbs ROM latency so that downstream back-pressure never drops an instruction.

---
 rtl/qs_srt_pkg.sv | 25 ++
 rtl/qs_srt_fetch_queue.sv | 67 ++++++
 rtl/qs_srt_fetch.sv | 114 +++++++++++
 tb/tb_qs_srt_fetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_srt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qs_srt_pkg
// Description : Shared types for the qs_srt sort microsequencer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package qs_srt_pkg;

    localparam int c_PC_W   = 8;
    localparam int c_INST_W = 16;

    typedef logic [c_INST_W-1:0] inst_t;

    typedef struct packed {
        inst_t              inst;
        logic [c_PC_W-1:0]  pc;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/qs_srt_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : qs_srt_fetch_queue
// Description : Two-entry registered FIFO of fetched instructions; head is r_ent0.
// Revision    : 1.0 - initial release
// ============================================================================
module qs_srt_fetch_queue
    import qs_srt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic [1:0]   o_count,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= i_data;
                    else                 r_ent1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word becomes the head.
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);
    assign o_head  = r_ent0;

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && !i_flush && r_count == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(i_pop && !i_flush && r_count == 2'd0));

endmodule
`default_nettype wire

// File: rtl/qs_srt_fetch.sv
`default_nettype none
// ============================================================================
// Module      : qs_srt_fetch
// Description : Instruction fetch: PC generation, 1-cycle ROM read, 2-deep output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module qs_srt_fetch
    import qs_srt_pkg::*;
#(
    parameter int PC_W    = c_PC_W,
    parameter int Q_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_vld,
    input  logic [PC_W-1:0] start_pc,
    output logic            busy,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  inst_t           imem_rdata,
    output logic            fetch_vld,
    output inst_t           fetch_inst,
    output logic [PC_W-1:0] fetch_pc,
    input  logic            fetch_ack,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_inflight_pc;
    logic            r_inflight;

    logic            w_run;
    logic            w_fetch_vld;
    logic            w_pop;
    logic            w_push;
    logic            w_flush;
    logic            w_issue;
    logic [2:0]      w_credit_use;
    logic [1:0]      w_count;
    logic            w_empty;
    fetch_entry_t    w_head;
    fetch_entry_t    w_enq;

    assign w_run       = (r_state == FETCH_RUN);
    assign w_fetch_vld = w_run & ~w_empty;
    assign w_pop       = w_fetch_vld & fetch_ack;
    assign w_flush     = w_run & (redirect_vld | halt);
    // A return is dropped when a redirect or halt lands in its arrival cycle.
    assign w_push      = w_run & r_inflight & ~redirect_vld & ~halt;

    // Slots are counted after this cycle's transfer so that a steady ack sustains one word per cycle.
    assign w_credit_use = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};
    assign w_issue      = w_run & ~redirect_vld & ~halt & (w_credit_use < 3'(Q_DEPTH));

    assign w_enq = '{inst: imem_rdata, pc: r_inflight_pc};

    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_IDLE: if (start_vld) w_state_nxt = FETCH_RUN;
            FETCH_RUN:  if (halt)      w_state_nxt = FETCH_IDLE;
            default:                   w_state_nxt = FETCH_IDLE;
        endcase
    end

    always_comb begin
        busy       = w_run;
        imem_en    = w_issue;
        imem_addr  = r_pc;
        fetch_vld  = w_fetch_vld;
        fetch_inst = w_head.inst;
        fetch_pc   = w_head.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
            if (!w_run) begin
                if (start_vld) r_pc <= start_pc;
            end else if (!halt) begin
                if (redirect_vld) r_pc <= redirect_pc;
                else if (w_issue) r_pc <= r_pc + 1'b1;
            end
        end
    end

    qs_srt_fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_enq),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_qs_srt_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_qs_srt_fetch
// Description : Self-checking bench for qs_srt_fetch: directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qs_srt_fetch;
    import qs_srt_pkg::*;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_vld = 1'b0;
    logic [PC_W-1:0] start_pc = '0;
    logic            busy;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    inst_t           imem_rdata = '0;
    logic            fetch_vld;
    inst_t           fetch_inst;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_ack = 1'b0;
    logic            redirect_vld = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            halt = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qs_srt_fetch #(.PC_W(PC_W), .Q_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_vld    (start_vld),
        .start_pc     (start_pc),
        .busy         (busy),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .fetch_vld    (fetch_vld),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_ack    (fetch_ack),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .halt         (halt)
    );

    function automatic inst_t rom(input logic [PC_W-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) if (imem_en) imem_rdata <= rom(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program-order model: expected stream position, issue pointer, words owed to decode.
    bit              m_run = 1'b0;
    bit              m_prev_rst = 1'b0;
    bit              m_pop;
    logic [PC_W-1:0] m_exp_pc = '0;
    logic [PC_W-1:0] m_iss_pc = '0;
    int              m_out = 0;
    int              m_gap = 0;

    always @(negedge clk) begin
        if (m_prev_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_vld", fetch_vld, 0);
            chk("rst_en", imem_en, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_pc", fetch_pc, 0);
            chk("rst_inst", fetch_inst, 0);
        end
        m_prev_rst = rst;
        if (rst) begin
            m_run = 1'b0;
            m_out = 0;
        end else if (!m_run) begin
            chk("idle_busy", busy, 0);
            chk("idle_vld", fetch_vld, 0);
            chk("idle_en", imem_en, 0);
            if (start_vld) begin
                m_run    = 1'b1;
                m_exp_pc = start_pc;
                m_iss_pc = start_pc;
                m_out    = 0;
                m_gap    = 0;
            end
        end else begin
            chk("run_busy", busy, 1);
            m_pop = fetch_vld && fetch_ack;
            if (fetch_vld) begin
                chk("fetch_pc", fetch_pc, m_exp_pc);
                chk("fetch_inst", fetch_inst, rom(fetch_pc));
                m_gap = 0;
            end else begin
                m_gap++;
                chk("fetch_gap_le2", m_gap <= 2, 1);
            end
            if (imem_en) begin
                chk("issue_addr", imem_addr, m_iss_pc);
                chk("issue_credit", (m_out - int'(m_pop) + 1) <= 2, 1);
                chk("issue_while_kill", redirect_vld | halt, 0);
            end
            if (halt) begin
                m_run = 1'b0;
                m_out = 0;
            end else if (redirect_vld) begin
                m_exp_pc = redirect_pc;
                m_iss_pc = redirect_pc;
                m_out    = 0;
                m_gap    = 0;
            end else begin
                if (m_pop) begin
                    m_exp_pc++;
                    m_out--;
                end
                if (imem_en) begin
                    m_iss_pc++;
                    m_out++;
                end
            end
        end
    end

    task automatic stop();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        fetch_ack = 1'b0;
    endtask

    task automatic begin_at(input logic [PC_W-1:0] pc, input logic ack);
        start_pc  = pc;
        start_vld = 1'b1;
        fetch_ack = ack;
        tick();
        start_vld = 1'b0;
    endtask

    initial begin
        int en_cnt;
        int hold_ok;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Start latency and steady one-per-cycle delivery.
        begin_at(8'h10, 1'b1);
        #1;
        chk("t1_busy_c1", busy, 1);
        chk("t1_en_c1", imem_en, 1);
        chk("t1_addr_c1", imem_addr, 8'h10);
        tick(); #1;
        chk("t1_vld_c2", fetch_vld, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("t1_vld", fetch_vld, 1);
            chk("t1_pc", fetch_pc, 32'h10 + i);
        end
        stop(); #1;
        chk("t1_halt_busy", busy, 0);

        // Back-pressure: only two reads outstanding, head held, no loss on release.
        begin_at(8'h10, 1'b0);
        en_cnt = 0;
        hold_ok = 0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            en_cnt += int'(imem_en);
            if (c >= 3 && fetch_vld && fetch_pc == 8'h10) hold_ok++;
            tick();
        end
        chk("t2_reads", en_cnt, 2);
        chk("t2_hold", hold_ok, 5);
        fetch_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_vld", fetch_vld, 1);
            chk("t2_pc", fetch_pc, 32'h10 + i);
            tick();
        end
        stop();

        // Redirect drops queued and inflight words.
        begin_at(8'h20, 1'b1);
        repeat (3) tick();
        redirect_vld = 1'b1;
        redirect_pc  = 8'h40;
        fetch_ack    = 1'b0;
        #1;
        chk("t3_head", fetch_pc, 8'h21);
        tick();
        redirect_vld = 1'b0;
        fetch_ack    = 1'b1;
        #1; chk("t3_vld_r1", fetch_vld, 0);
        tick(); #1; chk("t3_vld_r2", fetch_vld, 0);
        tick(); #1;
        chk("t3_vld_r3", fetch_vld, 1);
        chk("t3_pc_r3", fetch_pc, 8'h40);
        stop();

        // Redirect with acked head.
        begin_at(8'h30, 1'b0);
        tick(); tick();
        fetch_ack    = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h05;
        #1;
        chk("t4_head", fetch_pc, 8'h30);
        tick();
        redirect_vld = 1'b0;
        #1; chk("t4_vld_r1", fetch_vld, 0);
        tick(); #1; chk("t4_vld_r2", fetch_vld, 0);
        tick(); #1;
        chk("t4_vld_r3", fetch_vld, 1);
        chk("t4_pc_r3", fetch_pc, 8'h05);
        stop();

        // PC wrap, then halt beating a same-cycle redirect.
        begin_at(8'hFE, 1'b1);
        tick(); tick(); #1;
        chk("t5_pc_fe", fetch_pc, 8'hFE);
        tick(); #1;
        chk("t5_pc_ff", fetch_pc, 8'hFF);
        tick();
        halt         = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 8'h77;
        #1;
        chk("t5_pc_00", fetch_pc, 8'h00);
        tick();
        halt         = 1'b0;
        redirect_vld = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_vld", fetch_vld, 0);
        chk("t5_en", imem_en, 0);
        repeat (3) begin
            tick(); #1;
            chk("t5_en_after", imem_en, 0);
        end
        fetch_ack = 1'b0;

        // Mid-run reset with a read in flight; start_vld during RUN ignored.
        begin_at(8'h50, 1'b0);
        tick();
        start_vld = 1'b1;
        start_pc  = 8'h99;
        tick();
        start_vld = 1'b0;
        rst       = 1'b1;
        #1;
        chk("t6_pre_pc", fetch_pc, 8'h50);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_vld", fetch_vld, 0);
        chk("t6_addr", imem_addr, 0);
        tick(); #1;
        chk("t6_vld_after", fetch_vld, 0);
        begin_at(8'h60, 1'b1);
        tick(); tick(); #1;
        chk("t6_restart_pc", fetch_pc, 8'h60);
        stop();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            start_vld    = ($urandom_range(0, 7) == 0);
            start_pc     = 8'($urandom);
            fetch_ack    = ($urandom_range(0, 3) != 0);
            redirect_vld = ($urandom_range(0, 15) == 0);
            redirect_pc  = 8'($urandom);
            halt         = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst          = 1'b0;
        start_vld    = 1'b0;
        redirect_vld = 1'b0;
        halt         = 1'b0;
        fetch_ack    = 1'b1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
